// File: rtl/pacman_movement_pkg.sv
// Shared constants, direction type and helpers for the Pac-Man movement engine.
package pacman_movement_pkg;

    // Playfield geometry in pixels and tiles
    localparam int H_VISIBLE_AREA = 224;
    localparam int V_VISIBLE_AREA = 288;
    localparam int TILE_SIZE      = 8;
    localparam int MAP_STRIDE     = 32;
    localparam int TILE_COLS      = 28;
    localparam int TILE_ROWS      = 36;
    localparam int MAP_CELLS      = MAP_STRIDE * TILE_ROWS;

    // Start position and speed
    localparam int X_START = 112;
    localparam int Y_START = 208;
    localparam int STEP    = 1;

    // Largest legal sprite coordinates (last tile column / row)
    localparam logic [8:0] X_MAX = 9'(H_VISIBLE_AREA - TILE_SIZE);
    localparam logic [8:0] Y_MAX = 9'(V_VISIBLE_AREA - TILE_SIZE);

    // Tile codes: everything at or above WALL_MIN blocks movement
    localparam logic [3:0] TILE_EMPTY  = 4'h0;
    localparam logic [3:0] TILE_COOKIE = 4'h1;
    localparam logic [3:0] TILE_POWER  = 4'h2;
    localparam logic [3:0] WALL_MIN    = 4'h3;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // True when b points the opposite way to a (NONE has no opposite)
    function automatic logic is_opposite(input dir_t a, input dir_t b);
        logic opp;
        opp = 1'b0;
        case (a)
            DIR_UP:    opp = (b == DIR_DOWN);
            DIR_DOWN:  opp = (b == DIR_UP);
            DIR_LEFT:  opp = (b == DIR_RIGHT);
            DIR_RIGHT: opp = (b == DIR_LEFT);
            default:   opp = 1'b0;
        endcase
        return opp;
    endfunction

    // Passable tile codes are empty, cookie and power cookie
    function automatic logic code_passable(input logic [3:0] code);
        return code < WALL_MIN;
    endfunction

endpackage

// File: rtl/pacman_movement_tile_check.sv
// Combinational lookup: is the tile next to (x,y) in direction dir passable?
// Columns wrap around through the tunnel; rows off the board count as walls.
module pacman_movement_tile_check
    import pacman_movement_pkg::*;
(
    input  logic [8:0]                 x_i,
    input  logic [8:0]                 y_i,
    input  dir_t                       dir_i,
    input  logic [MAP_CELLS-1:0][3:0]  map_i,
    output logic                       passable_o
);

    logic [6:0]  col;
    logic [6:0]  row;
    logic [6:0]  tgt_col;
    logic [6:0]  tgt_row;
    logic        in_range;
    logic [10:0] idx;
    logic        unused_fine;

    // Only the tile coordinates matter; pixel offsets inside a tile do not
    assign col         = {1'b0, x_i[8:3]};
    assign row         = {1'b0, y_i[8:3]};
    assign unused_fine = ^{x_i[2:0], y_i[2:0]};

    // Neighbouring tile for the requested direction, with tunnel wrap
    always_comb begin
        tgt_col  = col;
        tgt_row  = row;
        in_range = 1'b1;
        case (dir_i)
            DIR_RIGHT: tgt_col = (col >= 7'(TILE_COLS - 1)) ? 7'd0 : col + 7'd1;
            DIR_LEFT:  tgt_col = (col == 7'd0) ? 7'(TILE_COLS - 1) : col - 7'd1;
            DIR_UP: begin
                if (row == 7'd0) in_range = 1'b0;
                else             tgt_row  = row - 7'd1;
            end
            DIR_DOWN: begin
                if (row >= 7'(TILE_ROWS - 1)) in_range = 1'b0;
                else                          tgt_row  = row + 7'd1;
            end
            default: in_range = 1'b0;
        endcase
    end

    // Row-major map index with 32-entry stride, widened before the add
    assign idx        = 11'(tgt_col) + (11'(tgt_row) << 5);
    assign passable_o = in_range && code_passable(map_i[idx]);

endmodule

// File: rtl/pacman_movement.sv
// Pac-Man position engine: latches the most recent button request and, once
// per frame, decides the travel direction and advances the sprite by STEP.
module pacman_movement
    import pacman_movement_pkg::*;
(
    input  logic                       vga_pix_clk,
    input  logic                       rst,
    input  logic                       frame_stb,
    input  logic [7:0]                 sx,
    input  logic [8:0]                 sy,
    input  logic                       BTNU,
    input  logic                       BTND,
    input  logic                       BTNR,
    input  logic                       BTNL,
    input  logic [MAP_CELLS-1:0][3:0]  MAP,
    output logic [8:0]                 x_pac,
    output logic [8:0]                 y_pac,
    output dir_t                       dbg_cur_dir
);

    // Handshake note: there is no valid/ready pair here; frame_stb is a
    // single-cycle qualifier and the position outputs are plain registers
    // that change only on the cycle after a frame_stb.

    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    dir_t       cur_dir_q, cur_dir_d;
    dir_t       req_dir_q, req_dir_d;
    logic       aligned;
    logic       req_pass;
    logic       cur_pass;
    logic       unused_scan;

    // Scan position is reserved for future use
    assign unused_scan = ^{sx, sy};

    assign aligned = (x_q[2:0] == 3'd0) && (y_q[2:0] == 3'd0);

    pacman_movement_tile_check u_req_check (
        .x_i        (x_q),
        .y_i        (y_q),
        .dir_i      (req_dir_q),
        .map_i      (MAP),
        .passable_o (req_pass)
    );

    pacman_movement_tile_check u_cur_check (
        .x_i        (x_q),
        .y_i        (y_q),
        .dir_i      (cur_dir_q),
        .map_i      (MAP),
        .passable_o (cur_pass)
    );

    // State register: position, travel direction and buffered request
    always_ff @(posedge vga_pix_clk) begin
        if (!rst) begin
            x_q       <= 9'(X_START);
            y_q       <= 9'(Y_START);
            cur_dir_q <= DIR_NONE;
            req_dir_q <= DIR_NONE;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            cur_dir_q <= cur_dir_d;
            req_dir_q <= req_dir_d;
        end
    end

    // Request capture: highest-priority pressed button, else keep the last one
    always_comb begin
        req_dir_d = req_dir_q;
        if      (BTNU) req_dir_d = DIR_UP;
        else if (BTND) req_dir_d = DIR_DOWN;
        else if (BTNL) req_dir_d = DIR_LEFT;
        else if (BTNR) req_dir_d = DIR_RIGHT;
    end

    // Next direction: reversals are instant, turns and stops only on tile grid
    always_comb begin
        cur_dir_d = cur_dir_q;
        if (frame_stb) begin
            if (is_opposite(cur_dir_q, req_dir_q)) begin
                cur_dir_d = req_dir_q;
            end else if (aligned && (req_dir_q != DIR_NONE) && req_pass) begin
                cur_dir_d = req_dir_q;
            end else if (aligned && !cur_pass) begin
                cur_dir_d = DIR_NONE;
            end
        end
    end

    // Position update in the direction chosen for this frame, with tunnel wrap
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_stb) begin
            case (cur_dir_d)
                DIR_RIGHT: x_d = (x_q >= X_MAX) ? 9'd0 : x_q + 9'(STEP);
                DIR_LEFT:  x_d = (x_q == 9'd0) ? X_MAX : x_q - 9'(STEP);
                DIR_UP:    if (y_q != 9'd0) y_d = y_q - 9'(STEP);
                DIR_DOWN:  if (y_q < Y_MAX) y_d = y_q + 9'(STEP);
                default: begin
                    x_d = x_q;
                    y_d = y_q;
                end
            endcase
        end
    end

    assign x_pac       = x_q;
    assign y_pac       = y_q;
    assign dbg_cur_dir = cur_dir_q;

endmodule

// File: tb/tb_pacman_movement.sv
// Directed bench for pacman_movement: a vector table of button/frame steps
// with hand-computed positions, followed by a few timing corner sequences.
module tb_pacman_movement;
    import pacman_movement_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       frame_stb;
    logic [7:0]                 sx;
    logic [8:0]                 sy;
    logic                       BTNU, BTND, BTNR, BTNL;
    logic [MAP_CELLS-1:0][3:0]  map;
    logic [8:0]                 x_pac;
    logic [8:0]                 y_pac;
    dir_t                       dbg_cur_dir;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit         do_rst;
        int         map_id;
        logic [3:0] btn;      // {U, D, L, R}
        int         frames;
        int         exp_x;
        int         exp_y;
        string      name;
    } vec_t;

    vec_t vecs[$];

    pacman_movement dut (
        .vga_pix_clk (clk),
        .rst         (rst),
        .frame_stb   (frame_stb),
        .sx          (sx),
        .sy          (sy),
        .BTNU        (BTNU),
        .BTND        (BTND),
        .BTNR        (BTNR),
        .BTNL        (BTNL),
        .MAP         (map),
        .x_pac       (x_pac),
        .y_pac       (y_pac),
        .dbg_cur_dir (dbg_cur_dir)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Map 0: everything wall except the whole of row 26.
    // Map 1: row 26 open for columns 0..15 only, plus tile (15,25) open.
    task automatic load_map(input int id);
        for (int i = 0; i < MAP_CELLS; i++) map[i] = 4'hF;
        for (int c = 0; c < TILE_COLS; c++)
            if (id == 0 || c <= 15) map[c + 26 * 32] = 4'h0;
        if (id == 1) map[15 + 25 * 32] = 4'h0;
    endtask

    // Driver tasks
    task automatic press(input logic [3:0] b);
        {BTNU, BTND, BTNL, BTNR} = b;
        tick();
        {BTNU, BTND, BTNL, BTNR} = 4'b0000;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_stb = 1'b1;
            tick();
            frame_stb = 1'b0;
            tick();
        end
    endtask

    // Scoreboard check
    task automatic check(input string name, input int ex, input int ey);
        n_vec++;
        if (x_pac !== 9'(ex) || y_pac !== 9'(ey)) begin
            n_bad++;
            $display("FAIL %s: got x_pac=%0d y_pac=%0d, expected x=%0d y=%0d",
                     name, x_pac, y_pac, ex, ey);
        end
    endtask

    task automatic add(input bit r, input int m, input logic [3:0] b, input int f,
                       input int ex, input int ey, input string nm);
        vec_t v;
        v.do_rst = r;  v.map_id = m; v.btn = b; v.frames = f;
        v.exp_x = ex;  v.exp_y = ey; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0; frame_stb = 1'b0; sx = '0; sy = '0;
        {BTNU, BTND, BTNL, BTNR} = 4'b0000;
        load_map(0);

        // Open corridor, reversal and tunnel
        add(1, 0, 4'b0000,   0, 112, 208, "reset");
        add(0, 0, 4'b0000,   5, 112, 208, "idle_frames");
        add(0, 0, 4'b0001,   8, 120, 208, "corridor_right");
        add(0, 0, 4'b0000,   3, 123, 208, "keep_right");
        add(1, 0, 4'b0001,   3, 115, 208, "to_115");
        add(0, 0, 4'b0010,   1, 114, 208, "reversal");
        add(0, 0, 4'b0000, 114,   0, 208, "run_to_0");
        add(0, 0, 4'b0000,   1, 216, 208, "tunnel_left");
        add(0, 0, 4'b0001,   1,   0, 208, "tunnel_right");
        add(0, 0, 4'b0000,   1,   1, 208, "after_wrap");
        // Button priority against walls above and below
        add(1, 0, 4'b1111,   2, 112, 208, "prio_up_blocked");
        add(0, 0, 4'b0101,   2, 112, 208, "prio_down_blocked");
        add(0, 0, 4'b0011,   1, 111, 208, "prio_left");
        // Wall stop
        add(1, 1, 4'b0001,   8, 120, 208, "wall_approach");
        add(0, 1, 4'b0000,  10, 120, 208, "wall_stop");
        // Buffered turn
        add(1, 1, 4'b0001,   1, 113, 208, "start_right");
        add(0, 1, 4'b1000,   7, 120, 208, "buffered_continue");
        add(0, 1, 4'b0000,   1, 120, 207, "turn_up");
        add(0, 1, 4'b0000,   8, 120, 200, "stop_top");
        add(0, 1, 4'b0100,   1, 120, 201, "down_again");

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) begin
                load_map(vecs[i].map_id);
                do_reset();
            end
            if (vecs[i].btn != 4'b0000) press(vecs[i].btn);
            frames(vecs[i].frames);
            check(vecs[i].name, vecs[i].exp_x, vecs[i].exp_y);
        end

        // Outputs stay put with no frame strobes
        load_map(0);
        do_reset();
        press(4'b0001);
        frames(8);
        repeat (1000) tick();
        check("hold_no_frames", 120, 208);

        // Reset wins over a coincident frame strobe mid-motion
        do_reset();
        press(4'b0001);
        frames(3);
        check("pre_reset_motion", 115, 208);
        rst = 1'b0;
        frame_stb = 1'b1;
        tick();
        rst = 1'b1;
        frame_stb = 1'b0;
        tick();
        check("reset_over_frame", 112, 208);

        // A button arriving on the strobe edge only counts from the next frame
        BTNR = 1'b1;
        frame_stb = 1'b1;
        tick();
        BTNR = 1'b0;
        frame_stb = 1'b0;
        tick();
        check("coincident_button", 112, 208);
        frames(1);
        check("button_next_frame", 113, 208);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pacman_movement.md
Name: pacman_movement

Overview:
- Player-position engine for the Pac-Man game on a 224x288 playfield of 28x36 tiles, 8x8 pixels each.
- Samples the four direction buttons and advances the Pac-Man sprite's top-left pixel coordinate once per video frame.
- Collision data comes from the 4-bit tile map owned by pacman_game.
- Outputs x_pac/y_pac feed pacman_game's sprite compositor and its cookie/candy BRAM address.

Parameters:
- H_MAP_WIDTH, params::pacman::H_VISIBLE_AREA (224), playfield width in pixels.
- V_MAP_HEIGHT, params::pacman::V_VISIBLE_AREA (288), playfield height in pixels.
- MAP_STRIDE, 32, tile columns per map row in MAP storage; index = col + row*32.
- X_START, 112, reset x (tile column 14).
- Y_START, 208, reset y (tile row 26).
- STEP, 1, pixels moved per frame.
- WALL_MIN, 4'h3, tile codes >= WALL_MIN are walls; codes 0..2 (empty, cookie, power cookie) are passable.

Ports:
- vga_pix_clk  in  1  sole clock.
- rst  in  1  synchronous, active-low reset.
- frame_stb  in  1  one-cycle pulse at the start of each frame.
- sx  in  $clog2(H_MAP_WIDTH)=8  current scan x; reserved, ignored.
- sy  in  $clog2(V_MAP_HEIGHT)=9  current scan y; reserved, ignored.
- BTNU, BTND, BTNR, BTNL  in  1 each  active-high, level direction buttons, already synchronised.
- MAP  in  [3:0] x 1152 (32*36)  tile map, read combinationally.
- x_pac  out  9  sprite top-left x.
- y_pac  out  9  sprite top-left y.

Behaviour:
- Reset (rst==0 at a vga_pix_clk edge):
  - x_pac=X_START, y_pac=Y_START.
  - cur_dir=NONE, req_dir=NONE.
- Direction codes: NONE, UP, DOWN, LEFT, RIGHT.
- req_dir, updated every cycle:
  - If any button is high, req_dir takes the highest-priority pressed button, priority U > D > L > R.
  - If no button is high, req_dir holds its value (buffered turn).
- Movement is evaluated only on cycles with frame_stb==1. New x_pac/y_pac are visible the cycle after the frame_stb edge. Outputs are stable otherwise.
- Aligned means x_pac[2:0]==0 and y_pac[2:0]==0. Tile (c,r) = (x_pac>>3, y_pac>>3).
- Target tile for direction d:
  - RIGHT: (c+1, r).
  - LEFT: (c-1, r).
  - UP: (c, r-1).
  - DOWN: (c, r+1).
- Passability:
  - Column outside 0..27 wraps modulo 28 (tunnel).
  - Row outside 0..35 is a wall.
  - Otherwise the tile is passable iff MAP[col + row*32] < WALL_MIN.
- On frame_stb, the order is:
  1. If req_dir is the opposite of cur_dir, cur_dir <= req_dir immediately, aligned or not.
  2. Else, if aligned and req_dir!=NONE and req_dir's target is passable, cur_dir <= req_dir.
  3. Else, if aligned and cur_dir's target is a wall, cur_dir <= NONE and there is no move.
  4. Move STEP pixels in the resulting cur_dir. When not aligned, motion continues with no wall check.
- Step 4 uses the direction decided in steps 1-3 of the same frame.
- Horizontal wrap:
  - LEFT at x_pac==0 yields x_pac = H_MAP_WIDTH-8 = 216.
  - RIGHT at x_pac==216 yields 0.
  - x_pac never exceeds 216 and y_pac never exceeds 280.
- Arithmetic is 9-bit unsigned. Tile indices are computed at 7 bits, then the product is widened to 11 bits before indexing.
- Reset asserted mid-motion overrides the frame_stb update in the same cycle.
- A frame_stb coinciding with a button change uses req_dir as registered before that edge.

Decomposition:
- Package params::pacman: H_VISIBLE_AREA, V_VISIBLE_AREA, tile size 8, MAP_STRIDE, 28/36 tile counts, dir_t enum (NONE/UP/DOWN/LEFT/RIGHT), tile code constants (EMPTY=0, COOKIE=1, POWER=2, WALL_MIN=3).
- One sub-module, pacman_tile_check: combinational; takes x, y, dir, MAP; returns passable. It is instantiated twice, for req_dir and cur_dir.

Test Plan:
- Reset: hold rst=0 for 2 clocks -> x_pac=112, y_pac=208, no motion over 5 frame_stb pulses with buttons idle.
- Open corridor: row 26 all 0, BTNR pulsed once, 8 frame_stb -> x_pac=120; with no frame_stb for 1000 clocks, outputs unchanged.
- Wall stop: tile (16,26)=4'hF, moving right from 112 -> stops at x_pac=120 and stays there for 10 further frames.
- Buffered turn: moving right, press BTNU at x=113 while tile (15,25)=0 -> x continues to 120, then y decreases 208->207 on the next frame.
- Reversal: at x=115 moving right, BTNL -> next frame x=114.
- Tunnel: x_pac=0 moving left on a passable row -> next frame x_pac=216; moving right from 216 -> 0.
